// File: rtl/flopenr_load_arbiter_if.sv
// Request/acknowledge bundle between the requesters, the consumer and the load
// arbiter for the shared enabled register.
interface flopenr_load_arbiter_if #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 4
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  q_ack;
  logic [NREQ-1:0]       gnt;
  logic                  en;
  logic [WIDTH-1:0]      d;
  logic                  q_valid;
  logic [IW-1:0]         q_owner;
  logic                  busy;

  modport master (
    output req, req_data, q_ack,
    input  gnt, en, d, q_valid, q_owner, busy
  );

  modport slave (
    input  req, req_data, q_ack,
    output gnt, en, d, q_valid, q_owner, busy
  );
endinterface

// File: rtl/flopenr_load_arbiter.sv
// Round-robin controller that sequences writes into the shared 64-bit flopenr
// through IDLE -> LOAD -> HOLD and keeps the loaded value valid until acknowledged.
module flopenr_load_arbiter #(
  parameter int WIDTH       = 64,
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  flopenr_load_arbiter_if.slave   bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] pick;
  logic [IW-1:0] idx;
  logic          found;
  logic          load_ok;

  // first requester at or after ptr, wrapping modulo NREQ
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IW'((int'(ptr) + i) % NREQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A withdrawn request in LOAD aborts without touching ptr; HOLD ignores
  // acknowledges until the hold counter has saturated.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          owner_nxt = pick;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (bus.req[owner]) begin
          ptr_nxt   = (owner == LAST) ? '0 : owner + IW'(1);
          cnt_nxt   = '0;
          state_nxt = HOLD;
        end else begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (cnt == CMAX) begin
          if (bus.q_ack) state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ok = (state == LOAD) && bus.req[owner];
    bus.gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.gnt[i] = load_ok && (owner == IW'(i));
    end
  end

  assign bus.en      = load_ok;
  assign bus.d       = bus.req_data[int'(owner)*WIDTH +: WIDTH];
  assign bus.q_valid = (state == HOLD);
  assign bus.q_owner = owner;
  assign bus.busy    = (state != IDLE);
endmodule
